// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone classic master bridge: the bridge FSM
// state encoding and the default widths/limits used as parameter defaults.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int adr_width_def      = 8;
  localparam int dat_width_def      = 32;
  localparam int max_retries_def    = 3;
  localparam int timeout_cycles_def = 16;

  // IDLE: waiting for a request; BUS: cyc/stb asserted; BACKOFF: one idle
  // bus cycle between retries; RESP: holding the response for the consumer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } bridge_state_t;

endpackage : wb_pkg

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
// Wishbone classic initiator. Turns a valid/ready request into a single
// Wishbone read or write cycle and returns a valid/ready response. A slave
// retry (rty) causes a one-cycle bus release and a new attempt, up to
// max_retries times; a slave that answers neither ack nor rty within
// timeout_cycles stb cycles ends the transfer. Both failures are reported as
// rsp_err with rsp_datrd forced to zero.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_we/req_adr/req_datwr/req_sel  request attributes, latched on accept
//   rsp_valid/rsp_ready          response handshake
//   rsp_datrd/rsp_err            read data (0 for writes/errors), failure flag
//   wb_adr/wb_datwr/wb_sel/wb_we/wb_stb/wb_cyc  Wishbone master outputs
//   wb_datrd/wb_ack/wb_rty       Wishbone master inputs
// All outputs are registered.
// -----------------------------------------------------------------------------
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int adr_width      = adr_width_def,
  parameter int dat_width      = dat_width_def,
  parameter int sel_width      = dat_width / 8,
  parameter int max_retries    = max_retries_def,
  parameter int timeout_cycles = timeout_cycles_def
) (
  input  logic                 clock,
  input  logic                 reset,
  // request port
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [adr_width-1:0] req_adr,
  input  logic [dat_width-1:0] req_datwr,
  input  logic [sel_width-1:0] req_sel,
  // response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dat_width-1:0] rsp_datrd,
  output logic                 rsp_err,
  // Wishbone master port
  output logic [adr_width-1:0] wb_adr,
  output logic [dat_width-1:0] wb_datwr,
  output logic [sel_width-1:0] wb_sel,
  output logic                 wb_we,
  output logic                 wb_stb,
  output logic                 wb_cyc,
  input  logic [dat_width-1:0] wb_datrd,
  input  logic                 wb_ack,
  input  logic                 wb_rty
);

  localparam int wait_w  = $clog2(timeout_cycles) + 1;
  localparam int retry_w = $clog2(max_retries + 1) + 1;

  localparam logic [wait_w-1:0]  wait_last = wait_w'(timeout_cycles - 1);
  localparam logic [wait_w-1:0]  wait_one  = wait_w'(1);
  localparam logic [retry_w-1:0] retry_max = retry_w'(max_retries);
  localparam logic [retry_w-1:0] retry_one = retry_w'(1);

  bridge_state_t        state;
  logic [wait_w-1:0]    wait_cnt;
  logic [retry_w-1:0]   retry_cnt;

  // Bridge FSM: request latch, bus phase sequencing, retry/timeout handling
  // and response hold. The wb_* attribute outputs double as the latched
  // request, so they stay constant for the whole transfer including retries.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= {wait_w{1'b0}};
      retry_cnt <= {retry_w{1'b0}};
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_datrd <= {dat_width{1'b0}};
      wb_adr    <= {adr_width{1'b0}};
      wb_datwr  <= {dat_width{1'b0}};
      wb_sel    <= {sel_width{1'b0}};
      wb_we     <= 1'b0;
      wb_stb    <= 1'b0;
      wb_cyc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wb_we     <= req_we;
            wb_adr    <= req_adr;
            wb_datwr  <= req_datwr;
            wb_sel    <= req_sel;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            retry_cnt <= {retry_w{1'b0}};
            wait_cnt  <= {wait_w{1'b0}};
            req_ready <= 1'b0;
            state     <= BUS;
          end else begin
            req_ready <= 1'b1;
          end
        end

        BUS: begin
          // ack takes priority over a simultaneous rty
          if (wb_ack) begin
            rsp_datrd <= wb_we ? {dat_width{1'b0}} : wb_datrd;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            state     <= RESP;
          end else if (wb_rty) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            if (retry_cnt < retry_max) begin
              retry_cnt <= retry_cnt + retry_one;
              state     <= BACKOFF;
            end else begin
              rsp_datrd <= {dat_width{1'b0}};
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else if (wait_cnt == wait_last) begin
            // this was the last permitted stb cycle without an answer
            rsp_datrd <= {dat_width{1'b0}};
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + wait_one;
          end
        end

        BACKOFF: begin
          wait_cnt <= {wait_w{1'b0}};
          wb_cyc   <= 1'b1;
          wb_stb   <= 1'b1;
          state    <= BUS;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end

        default: begin
          wb_cyc    <= 1'b0;
          wb_stb    <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : wb_master_bridge

// File: tb/tb_wb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_master_bridge
// Self-checking bench for wb_master_bridge (default parameters: 8-bit address,
// 32-bit data, 3 retries, 16-cycle timeout). A scripted slave answers each stb
// phase after a chosen number of wait cycles with ack, rty, both, or nothing.
// The expected outcome of a script is computed from the transfer rules.
// -----------------------------------------------------------------------------
module tb_wb_master_bridge;

  localparam int MAXR   = 3;
  localparam int TMO    = 16;
  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_RTY  = 2;
  localparam int K_BOTH = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_adr;
  logic [31:0] req_datwr;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_datrd;
  logic [7:0]  wb_adr;
  logic [31:0] wb_datwr, wb_datrd;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_rty;

  always #5 clock = ~clock;

  wb_master_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_datwr(req_datwr), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_datrd(rsp_datrd), .rsp_err(rsp_err),
    .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_stb(wb_stb), .wb_cyc(wb_cyc),
    .wb_datrd(wb_datrd), .wb_ack(wb_ack), .wb_rty(wb_rty)
  );

  int checks = 0;
  int failures = 0;

  // slave script: kind and wait cycles for each stb phase
  int sk[8];
  int sw[8];
  bit noise;  // drive ack/rty garbage whenever stb is low

  // observations from one transfer
  int          o_stb, o_phases, o_lat, o_bad, o_hold_bad, o_rdywait;
  logic [31:0] o_dat;
  logic        o_err, o_valid_after, o_rdy_after;

  // expectations from the reference model
  int   e_stb, e_phases, e_lat;
  logic e_err;

  // Reference model: walk the attempts of the script and apply the rules
  // (ack ends ok, rty retries up to MAXR times, silence ends after TMO cycles).
  task automatic model_outcome();
    int retries;
    retries  = 0;
    e_stb    = 0;
    e_phases = 0;
    e_err    = 1'b1;
    for (int a = 0; a < 8; a++) begin
      e_phases++;
      if (sk[a] != K_NONE && sw[a] < TMO) begin
        e_stb += sw[a] + 1;
        if (sk[a] == K_ACK || sk[a] == K_BOTH) begin
          e_err = 1'b0;
          break;
        end
        if (retries < MAXR) retries++;
        else break;
      end else begin
        e_stb += TMO;
        break;
      end
    end
    // stb cycles plus one backoff cycle between phases, response one later
    e_lat = e_stb + e_phases;
  endtask

  task automatic clear_script();
    for (int i = 0; i < 8; i++) begin
      sk[i] = K_NONE;
      sw[i] = 0;
    end
  endtask

  // Issue one request, act as the scripted slave, collect the response.
  task automatic do_txn(input logic we, input logic [7:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] rdata, input int hold);
    int   a, cnt, c;
    logic prev_stb;
    o_stb = 0; o_phases = 0; o_bad = 0; o_hold_bad = 0; o_rdywait = 0;
    while (req_ready !== 1'b1 && o_rdywait < 10) begin
      @(negedge clock);
      o_rdywait++;
    end
    req_valid = 1'b1; req_we = we; req_adr = adr; req_datwr = dat; req_sel = sel;
    @(negedge clock);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_adr = 8'($urandom); req_datwr = $urandom; req_sel = 4'($urandom);
    a = 0; cnt = 0; prev_stb = 1'b0; c = 1;
    while (c <= 200) begin
      wb_ack   = noise;
      wb_rty   = noise ? 1'($urandom) : 1'b0;
      wb_datrd = $urandom;
      if (rsp_valid === 1'b1) break;
      if (wb_cyc !== wb_stb) o_bad++;
      if (wb_stb === 1'b1) begin
        if (!prev_stb) o_phases++;
        if (wb_adr !== adr || wb_we !== we || wb_sel !== sel || wb_datwr !== dat) o_bad++;
        o_stb++;
        wb_ack = 1'b0;
        wb_rty = 1'b0;
        if (a < 8 && sk[a] != K_NONE && cnt == sw[a]) begin
          wb_ack = (sk[a] == K_ACK || sk[a] == K_BOTH);
          wb_rty = (sk[a] == K_RTY || sk[a] == K_BOTH);
          if (wb_ack) wb_datrd = rdata;
        end
        cnt++;
      end else if (prev_stb) begin
        a++;
        cnt = 0;
      end
      prev_stb = wb_stb;
      @(negedge clock);
      c++;
    end
    checks++;
    if (c > 200) begin
      failures++;
      $display("FAIL txn_response_wait: no rsp_valid within %0d cycles, required one", c - 1);
    end
    o_lat = c; o_dat = rsp_datrd; o_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_datrd !== o_dat || rsp_err !== o_err) o_hold_bad++;
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_rty = 1'b0;
    o_valid_after = rsp_valid;
    o_rdy_after   = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000", {req_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we});
    end
    checks++;
    if (wb_adr !== 8'h0 || wb_datwr !== 32'h0 || wb_sel !== 4'h0 || rsp_datrd !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: adr=%h datwr=%h sel=%h datrd=%h required all zero", wb_adr, wb_datwr, wb_sel, rsp_datrd);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b required 1", req_ready);
    end
  endtask

  task automatic test_read_ack();
    clear_script(); noise = 1'b0;
    sk[0] = K_ACK; sw[0] = 0;
    model_outcome();
    do_txn(1'b0, 8'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);
    checks++; if (o_stb !== 1) begin failures++; $display("FAIL read_stb_cycles: got %0d required 1", o_stb); end
    checks++; if (o_lat !== 2) begin failures++; $display("FAIL read_latency: got %0d required 2", o_lat); end
    checks++; if (o_dat !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data: got %h required deadbeef", o_dat); end
    checks++; if (o_err !== e_err) begin failures++; $display("FAIL read_err: got %b required %b", o_err, e_err); end
    checks++; if (o_valid_after !== 1'b0) begin failures++; $display("FAIL read_valid_drop: got %b required 0", o_valid_after); end
  endtask

  task automatic test_write_wait();
    clear_script(); noise = 1'b0;
    sk[0] = K_ACK; sw[0] = 3;
    model_outcome();
    do_txn(1'b1, 8'h20, 32'h12345678, 4'hF, 32'hFFFFFFFF, 0);
    checks++; if (o_stb !== e_stb) begin failures++; $display("FAIL write_stb_cycles: got %0d required %0d", o_stb, e_stb); end
    checks++; if (o_bad !== 0) begin failures++; $display("FAIL write_bus_stable: %0d unstable cycles, required 0", o_bad); end
    checks++; if (o_dat !== 32'h0) begin failures++; $display("FAIL write_data: got %h required 0", o_dat); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL write_err: got %b required 0", o_err); end
  endtask

  task automatic test_retry_then_ack();
    clear_script(); noise = 1'b1;
    sk[0] = K_RTY; sk[1] = K_RTY; sk[2] = K_ACK;
    model_outcome();
    do_txn(1'b0, 8'h44, 32'h0, 4'h3, 32'hA5A5A5A5, 0);
    checks++; if (o_phases !== 3) begin failures++; $display("FAIL retry_phases: got %0d required 3", o_phases); end
    checks++; if (o_lat !== e_lat) begin failures++; $display("FAIL retry_latency: got %0d required %0d", o_lat, e_lat); end
    checks++; if (o_dat !== 32'hA5A5A5A5 || o_err !== 1'b0) begin failures++; $display("FAIL retry_result: got %h/%b required a5a5a5a5/0", o_dat, o_err); end
  endtask

  task automatic test_retry_exhaust();
    clear_script(); noise = 1'b0;
    for (int i = 0; i < 8; i++) sk[i] = K_RTY;
    model_outcome();
    do_txn(1'b0, 8'h55, 32'h0, 4'hF, 32'h11111111, 5);
    checks++; if (o_phases !== 4) begin failures++; $display("FAIL exhaust_phases: got %0d required 4", o_phases); end
    checks++; if (o_err !== 1'b1 || o_dat !== 32'h0) begin failures++; $display("FAIL exhaust_result: got %h/%b required 0/1", o_dat, o_err); end
    checks++; if (o_hold_bad !== 0) begin failures++; $display("FAIL exhaust_hold: %0d unstable cycles, required 0", o_hold_bad); end
    checks++; if (o_valid_after !== 1'b0) begin failures++; $display("FAIL exhaust_valid_drop: got %b required 0", o_valid_after); end
  endtask

  task automatic test_timeout();
    clear_script(); noise = 1'b1;  // ack held high once stb drops: must be ignored
    model_outcome();
    do_txn(1'b0, 8'h66, 32'h0, 4'hF, 32'h22222222, 2);
    checks++; if (o_stb !== TMO) begin failures++; $display("FAIL timeout_stb_cycles: got %0d required %0d", o_stb, TMO); end
    checks++; if (o_err !== 1'b1 || o_dat !== 32'h0) begin failures++; $display("FAIL timeout_result: got %h/%b required 0/1", o_dat, o_err); end
    checks++; if (o_hold_bad !== 0) begin failures++; $display("FAIL timeout_late_ack: %0d disturbed cycles, required 0", o_hold_bad); end
    clear_script(); noise = 1'b0;
    sk[0] = K_BOTH; sw[0] = 1;
    model_outcome();
    do_txn(1'b0, 8'h67, 32'h0, 4'hF, 32'h0BADF00D, 0);
    checks++; if (o_err !== 1'b0 || o_dat !== 32'h0BADF00D || o_phases !== 1) begin failures++; $display("FAIL ack_rty_together: got %h/%b/%0d required 0badf00d/0/1", o_dat, o_err, o_phases); end
  endtask

  task automatic test_reset_mid();
    int seen;
    clear_script(); noise = 1'b0;
    wb_ack = 1'b0; wb_rty = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h33; req_sel = 4'hF;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (wb_stb !== 1'b1) begin failures++; $display("FAIL midreset_in_bus: stb=%b required 1", wb_stb); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({wb_cyc, wb_stb, rsp_valid} !== 3'b000) begin failures++; $display("FAIL midreset_drop: cyc/stb/valid=%b required 000", {wb_cyc, wb_stb, rsp_valid}); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_rsp: rsp_valid seen %0d cycles, required 0", seen); end
    sk[0] = K_ACK; sw[0] = 0;
    do_txn(1'b0, 8'h34, 32'h0, 4'hF, 32'hCAFEF00D, 0);
    checks++; if (o_dat !== 32'hCAFEF00D || o_err !== 1'b0) begin failures++; $display("FAIL midreset_next: got %h/%b required cafef00d/0", o_dat, o_err); end
  endtask

  task automatic test_back_to_back();
    clear_script(); noise = 1'b0;
    sk[0] = K_ACK; sw[0] = 0;
    do_txn(1'b1, 8'h70, 32'h01020304, 4'h5, 32'h0, 0);
    checks++; if (o_rdy_after !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b required 1", o_rdy_after); end
    do_txn(1'b0, 8'h71, 32'h0, 4'hA, 32'h77778888, 0);
    checks++; if (o_rdywait !== 0 || o_lat !== 2) begin failures++; $display("FAIL b2b_interval: wait=%0d lat=%0d required 0/2", o_rdywait, o_lat); end
  endtask

  task automatic test_random();
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat, rdata, exp_dat;
    logic [3:0]  sel;
    int          r;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        sk[i] = (r == 0) ? K_NONE : (r <= 4) ? K_ACK : (r <= 8) ? K_RTY : K_BOTH;
        sw[i] = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 4);
      end
      noise = 1'($urandom);
      we = 1'($urandom); adr = 8'($urandom); dat = $urandom; sel = 4'($urandom); rdata = $urandom;
      model_outcome();
      exp_dat = (e_err || we) ? 32'h0 : rdata;
      do_txn(we, adr, dat, sel, rdata, $urandom_range(0, 3));
      checks++;
      if (o_stb !== e_stb || o_phases !== e_phases || o_lat !== e_lat) begin
        failures++;
        $display("FAIL rand_timing[%0d]: stb/phases/lat got %0d/%0d/%0d required %0d/%0d/%0d", n, o_stb, o_phases, o_lat, e_stb, e_phases, e_lat);
      end
      checks++;
      if (o_dat !== exp_dat || o_err !== e_err) begin
        failures++;
        $display("FAIL rand_result[%0d]: got %h/%b required %h/%b", n, o_dat, o_err, exp_dat, e_err);
      end
      checks++;
      if (o_bad !== 0 || o_hold_bad !== 0 || o_valid_after !== 1'b0) begin
        failures++;
        $display("FAIL rand_stability[%0d]: bus=%0d hold=%0d valid_after=%b required 0/0/0", n, o_bad, o_hold_bad, o_valid_after);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = 8'h0;
    req_datwr = 32'h0; req_sel = 4'h0; rsp_ready = 1'b0;
    wb_datrd = 32'h0; wb_ack = 1'b0; wb_rty = 1'b0; noise = 1'b0;
    clear_script();
    test_reset();
    test_read_ack();
    test_write_wait();
    test_retry_then_ack();
    test_retry_exhaust();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_master_bridge
